// File: rtl/ocs_pkg.sv
// Shared OCS0 definitions: controller state encoding, ToR count, per-slot
// rotation constants and the peer lookup used by the controller and the OCS model.
package ocs_pkg;

    typedef enum logic [1:0] {IDLE, GUARD, ACTIVE, DRAIN} state_t;

    localparam int NUM_TOR = 8;
    localparam int TOR_W   = $clog2(NUM_TOR);

    localparam logic [TOR_W-1:0] ROT_SLOT0 = TOR_W'(1);
    localparam logic [TOR_W-1:0] ROT_SLOT1 = TOR_W'(3);

    localparam logic DIR_RX = 1'b0;
    localparam logic DIR_TX = 1'b1;

    // Rotation arithmetic wraps naturally in TOR_W bits, which is mod NUM_TOR.
    function automatic logic [TOR_W-1:0] peer_of(input logic [TOR_W-1:0] id,
                                                 input logic             slot,
                                                 input logic             dir);
        logic [TOR_W-1:0] rot;
        rot = slot ? ROT_SLOT1 : ROT_SLOT0;
        return dir ? (id - rot) : (id + rot);
    endfunction

endpackage

// File: rtl/ocs_slot_timer.sv
// Slot cycle counter: runs 0..SLOT_CYCLES-1 while counting and reports
// the cycles on which the slot phase is about to change.
module ocs_slot_timer #(
    parameter int SLOT_CYCLES  = 1000,
    parameter int GUARD_CYCLES = 64,
    parameter int DRAIN_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic count,
    output logic wrap,
    output logic guard_end,
    output logic drain_start
);

    localparam int CW = $clog2(SLOT_CYCLES);
    localparam logic [CW-1:0] LAST_CNT      = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] GUARD_END_CNT = CW'(GUARD_CYCLES - 1);
    localparam logic [CW-1:0] DRAIN_PRE_CNT = CW'(SLOT_CYCLES - DRAIN_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart || !count || wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Flags describe the count currently presented; the FSM acts on them at the next edge.
    assign wrap        = (cnt == LAST_CNT);
    assign guard_end   = (cnt == GUARD_END_CNT);
    assign drain_start = (cnt == DRAIN_PRE_CNT);

endmodule

// File: rtl/ocs_slot_ctrl.sv
// Per-ToR OCS0 slot controller: sequences GUARD/ACTIVE/DRAIN around each
// reconfiguration, drives slot_id and reports the current peer ToRs.
module ocs_slot_ctrl
    import ocs_pkg::*;
#(
    parameter int NUM_TOR      = 8,
    parameter int SLOT_CYCLES  = 1000,
    parameter int GUARD_CYCLES = 64,
    parameter int DRAIN_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [2:0]  i_tor_id,
    input  logic        i_run,
    input  logic        i_sync,
    input  logic        i_tx_busy,
    output logic        o_slot_id,
    output logic        o_tx_en,
    output logic        o_guard,
    output logic        o_slot_start,
    output logic [2:0]  o_peer_rx_id,
    output logic [2:0]  o_peer_tx_id,
    output logic [15:0] o_slot_cnt,
    output logic        o_overrun
);

    if (NUM_TOR != ocs_pkg::NUM_TOR || GUARD_CYCLES < 1 || DRAIN_CYCLES < 1 ||
        GUARD_CYCLES + DRAIN_CYCLES >= SLOT_CYCLES) begin : g_bad_params
        $error("ocs_slot_ctrl: illegal parameter combination");
    end

    state_t state, state_next;
    logic   wrap, guard_end, drain_start;
    logic   restart, advance_slot, load_peer, slot_next;

    // A sync only realigns a running controller; starting from IDLE is the same restart.
    assign restart = i_run && ((state == IDLE) || i_sync);

    ocs_slot_timer #(
        .SLOT_CYCLES  (SLOT_CYCLES),
        .GUARD_CYCLES (GUARD_CYCLES),
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) u_timer (
        .clk         (i_clk),
        .rst         (i_rst),
        .restart     (restart),
        .count       (state != IDLE),
        .wrap        (wrap),
        .guard_end   (guard_end),
        .drain_start (drain_start)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next   = state;
        advance_slot = 1'b0;
        case (state)
            IDLE:   if (i_run) state_next = GUARD;
            GUARD:  if (!i_run) state_next = DRAIN;
                    else if (guard_end) state_next = ACTIVE;
            ACTIVE: if (!i_run || drain_start) state_next = DRAIN;
            DRAIN:  if (wrap) begin
                        if (i_run) begin
                            state_next   = GUARD;
                            advance_slot = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end
            default: state_next = IDLE;
        endcase
        if (restart) begin
            state_next   = GUARD;
            advance_slot = 1'b0;
        end
    end

    assign slot_next = (restart || state_next == IDLE) ? 1'b0 :
                       advance_slot ? ~o_slot_id : o_slot_id;
    assign load_peer = restart || advance_slot || (state != IDLE && state_next == IDLE);

    // Outputs are registered from next-state so they line up with the presented count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_slot_id    <= 1'b0;
            o_tx_en      <= 1'b0;
            o_guard      <= 1'b0;
            o_slot_start <= 1'b0;
            o_peer_rx_id <= peer_of(i_tor_id, 1'b0, DIR_RX);
            o_peer_tx_id <= peer_of(i_tor_id, 1'b0, DIR_TX);
            o_slot_cnt   <= '0;
            o_overrun    <= 1'b0;
        end else begin
            o_slot_id    <= slot_next;
            o_tx_en      <= (state_next == ACTIVE);
            o_guard      <= (state_next == GUARD);
            o_slot_start <= (state == GUARD) && (state_next == ACTIVE);
            if (load_peer) begin
                o_peer_rx_id <= peer_of(i_tor_id, slot_next, DIR_RX);
                o_peer_tx_id <= peer_of(i_tor_id, slot_next, DIR_TX);
            end
            if (restart)           o_slot_cnt <= '0;
            else if (advance_slot) o_slot_cnt <= o_slot_cnt + 16'd1;
            if (restart && i_sync)                     o_overrun <= 1'b0;
            else if (advance_slot && i_tx_busy)        o_overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ocs_slot_ctrl.sv
// Directed bench for ocs_slot_ctrl with a short slot (20/4/2): vector table
// for the main sequences plus hand-written reset and mod-8 sequences.
module tb_ocs_slot_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [2:0]  i_tor_id;
    logic        i_run, i_sync, i_tx_busy;
    logic        o_slot_id, o_tx_en, o_guard, o_slot_start, o_overrun;
    logic [2:0]  o_peer_rx_id, o_peer_tx_id;
    logic [15:0] o_slot_cnt;

    ocs_slot_ctrl #(
        .NUM_TOR(8), .SLOT_CYCLES(20), .GUARD_CYCLES(4), .DRAIN_CYCLES(2)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_tor_id(i_tor_id), .i_run(i_run),
        .i_sync(i_sync), .i_tx_busy(i_tx_busy), .o_slot_id(o_slot_id),
        .o_tx_en(o_tx_en), .o_guard(o_guard), .o_slot_start(o_slot_start),
        .o_peer_rx_id(o_peer_rx_id), .o_peer_tx_id(o_peer_tx_id),
        .o_slot_cnt(o_slot_cnt), .o_overrun(o_overrun)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic        slot;
        logic        tx_en;
        logic        guard;
        logic        ss;
        logic [2:0]  rx;
        logic [2:0]  tx;
        logic [15:0] sc;
        logic        ov;
    } outs_t;

    typedef struct {
        string name;
        int    n;
        bit    run;
        bit    sync;
        bit    busy;
        outs_t exp;
    } vec_t;

    vec_t vecs[$];
    int   applied = 0;
    int   miscompares = 0;

    function automatic outs_t e(int slot, int txen, int guard, int ss,
                                int rx, int tx, int sc, int ov);
        outs_t o;
        o.slot = 1'(slot); o.tx_en = 1'(txen); o.guard = 1'(guard); o.ss = 1'(ss);
        o.rx = 3'(rx); o.tx = 3'(tx); o.sc = 16'(sc); o.ov = 1'(ov);
        return o;
    endfunction

    function automatic outs_t got_o();
        outs_t o;
        o.slot = o_slot_id; o.tx_en = o_tx_en; o.guard = o_guard; o.ss = o_slot_start;
        o.rx = o_peer_rx_id; o.tx = o_peer_tx_id; o.sc = o_slot_cnt; o.ov = o_overrun;
        return o;
    endfunction

    function automatic void add(string name, int n, bit run, bit sync, bit busy, outs_t exp);
        vec_t v;
        v.name = name; v.n = n; v.run = run; v.sync = sync; v.busy = busy; v.exp = exp;
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, outs_t exp);
        outs_t g;
        g = got_o();
        applied++;
        if (g !== exp) begin
            miscompares++;
            $display("FAIL %s: got slot=%b tx_en=%b guard=%b ss=%b rx=%0d tx=%0d cnt=%0d ov=%b, need slot=%b tx_en=%b guard=%b ss=%b rx=%0d tx=%0d cnt=%0d ov=%b",
                     name, g.slot, g.tx_en, g.guard, g.ss, g.rx, g.tx, g.sc, g.ov,
                     exp.slot, exp.tx_en, exp.guard, exp.ss, exp.rx, exp.tx, exp.sc, exp.ov);
        end
    endtask

    task automatic chk_int(string name, int got, int exp);
        applied++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, need %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        int tx_cnt, ss_cnt, g_cnt;

        // Nominal slot, id=2: peers 3/1 in slot 0 and 5/7 in slot 1.
        add("nom_cnt0",     1, 1, 0, 0, e(0,0,1,0,3,1,0,0));
        add("nom_cnt3",     3, 1, 0, 0, e(0,0,1,0,3,1,0,0));
        add("nom_start4",   1, 1, 0, 0, e(0,1,0,1,3,1,0,0));
        add("nom_cnt5",     1, 1, 0, 0, e(0,1,0,0,3,1,0,0));
        add("nom_cnt17",   12, 1, 0, 0, e(0,1,0,0,3,1,0,0));
        add("nom_drain18",  1, 1, 0, 0, e(0,0,0,0,3,1,0,0));
        add("nom_drain19",  1, 1, 0, 0, e(0,0,0,0,3,1,0,0));
        add("nom_wrap_s1",  1, 1, 0, 0, e(1,0,1,0,5,7,1,0));
        add("s1_active10", 10, 1, 0, 0, e(1,1,0,0,5,7,1,0));
        add("sync_active",  1, 1, 1, 0, e(0,0,1,0,3,1,0,0));
        add("sync_cnt3",    3, 1, 0, 0, e(0,0,1,0,3,1,0,0));
        add("sync_txback",  1, 1, 0, 0, e(0,1,0,1,3,1,0,0));
        add("drop_cnt8",    4, 1, 0, 0, e(0,1,0,0,3,1,0,0));
        add("drop_cnt9",    1, 0, 0, 0, e(0,0,0,0,3,1,0,0));
        add("drop_cnt19",  10, 0, 0, 0, e(0,0,0,0,3,1,0,0));
        add("drop_idle",    1, 0, 0, 0, e(0,0,0,0,3,1,0,0));
        add("idle_hold",    5, 0, 0, 0, e(0,0,0,0,3,1,0,0));
        add("idle_sync_norun", 2, 0, 1, 0, e(0,0,0,0,3,1,0,0));
        add("ov_start",     1, 1, 0, 0, e(0,0,1,0,3,1,0,0));
        add("ov_drain18",  18, 1, 0, 0, e(0,0,0,0,3,1,0,0));
        add("ov_set",       2, 1, 0, 1, e(1,0,1,0,5,7,1,1));
        add("ov_hold3",    60, 1, 0, 0, e(0,0,1,0,3,1,4,1));
        add("ov_sync_clr",  1, 1, 1, 0, e(0,0,1,0,3,1,0,0));

        i_rst = 1'b1; i_tor_id = 3'd2; i_run = 1'b0; i_sync = 1'b0; i_tx_busy = 1'b0;
        repeat (2) tick();
        chk("reset_state", e(0,0,0,0,3,1,0,0));
        i_rst = 1'b0;
        tick();
        chk("idle_after_reset", e(0,0,0,0,3,1,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            i_run = vecs[i].run; i_sync = vecs[i].sync; i_tx_busy = vecs[i].busy;
            for (int k = 0; k < vecs[i].n; k++) begin
                tick();
                i_sync = 1'b0;
            end
            chk(vecs[i].name, vecs[i].exp);
        end

        // Mod-8 peer wrap with id=6 loaded through reset.
        i_run = 1'b0; i_tx_busy = 1'b0;
        i_rst = 1'b1; i_tor_id = 3'd6;
        #1;
        chk("id6_reset", e(0,0,0,0,7,5,0,0));
        tick();
        i_rst = 1'b0;
        i_run = 1'b1;
        tick();
        chk("id6_slot0", e(0,0,1,0,7,5,0,0));
        repeat (20) tick();
        chk("id6_slot1", e(1,0,1,0,1,3,1,0));
        repeat (6) tick();
        chk("id6_s1_active", e(1,1,0,0,1,3,1,0));

        // Asynchronous reset mid-ACTIVE, checked before the next clock edge.
        #3 i_rst = 1'b1;
        #1;
        chk("async_rst", e(0,0,0,0,7,5,0,0));
        i_run = 1'b0; i_tor_id = 3'd2;
        repeat (2) tick();
        i_rst = 1'b0;
        i_run = 1'b1;
        tx_cnt = 0; ss_cnt = 0; g_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            tx_cnt += int'(o_tx_en);
            ss_cnt += int'(o_slot_start);
            g_cnt  += int'(o_guard);
            if (k == 4) chk("restart_start4", e(0,1,0,1,3,1,0,0));
        end
        chk_int("restart_tx_en_cycles", tx_cnt, 14);
        chk_int("restart_slot_starts", ss_cnt, 1);
        chk_int("restart_guard_cycles", g_cnt, 4);
        tick();
        chk("restart_wrap_s1", e(1,0,1,0,5,7,1,0));

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
